serial_add_unit: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/full_adder_bit.sv | 21 ++
 rtl/serial_add_unit.sv | 108 ++++++++++
 tb/tb_serial_add_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions.
// Serial adder FSM states and default width.
package arith_pkg;

  localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } add_state_e;

endpackage

// File: rtl/full_adder_bit.sv
// Gate-level 1-bit full adder.
// Two half-adder stages merged by an OR.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder, LSB first.
// One full-adder cell plus a carry flop.
module serial_add_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  add_state_e       st_q, st_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             fa_s;
  logic             fa_co;

  full_adder_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Next-state: load on accept, shift one bit per edge, publish on last.
  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    ps_d  = ps_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    c_d   = c_q;
    co_d  = co_q;
    unique case (st_q)
      IDLE, DONE: begin
        st_d = IDLE;
        if (start) begin
          a_d   = a;
          b_d   = b;
          ps_d  = '0;
          c_d   = 1'b0;
          cnt_d = '0;
          st_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        ps_d  = {fa_s, ps_q[WIDTH-1:1]};
        c_d   = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d = {fa_s, ps_q[WIDTH-1:1]};
          co_d  = fa_co;
          cnt_d = '0;
          st_d  = DONE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      ps_q  <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ps_q  <= ps_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      c_q   <= c_d;
      co_q  <= co_d;
    end
  end

  assign busy      = (st_q == SHIFT);
  assign done      = (st_q == DONE);
  assign sum       = sum_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit.
// Runs 8- and 16-bit instances side by side.
module tb_serial_add_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        st8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        busy8, done8, co8;

  logic        st16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, co16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .sum(sum8), .carry_out(co8)
  );

  serial_add_unit #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(st16),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .sum(sum16), .carry_out(co16)
  );

  task automatic chk(string tag, logic [31:0] o,
                     logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h",
             tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int w, logic s,
                       logic [15:0] a, logic [15:0] b);
    if (w == 8) begin
      st8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st16 = s; a16 = a; b16 = b;
    end
  endtask

  function automatic logic [16:0] res(int w);
    if (w == 8) return {8'd0, co8, sum8};
    return {co16, sum16};
  endfunction

  function automatic logic bsy(int w);
    return (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic dn(int w);
    return (w == 8) ? done8 : done16;
  endfunction

  // Accept a/b, then walk the SHIFT phase to the DONE cycle.
  // inj>=0 pulses start with junk operands mid-SHIFT.
  task automatic op(int w, logic [15:0] a,
                    logic [15:0] b, logic [16:0] prev,
                    logic [16:0] e, int inj);
    drive(w, 1'b1, a, b);
    tick();
    drive(w, 1'b0, ~a, ~b);
    for (int i = 0; i < w; i++) begin
      chk("busy", 32'(bsy(w)), 32'd1);
      chk("done_early", 32'(dn(w)), 32'd0);
      chk("hold", 32'(res(w)), 32'(prev));
      if (i == inj) drive(w, 1'b1, 16'h77, 16'h77);
      else drive(w, 1'b0, ~a, ~b);
      tick();
    end
    chk("done", 32'(dn(w)), 32'd1);
    chk("busy_off", 32'(bsy(w)), 32'd0);
    chk("result", 32'(res(w)), 32'(e));
  endtask

  task automatic fin(int w, logic [16:0] e);
    tick();
    chk("done_pulse", 32'(dn(w)), 32'd0);
    chk("idle_busy", 32'(bsy(w)), 32'd0);
    chk("held", 32'(res(w)), 32'(e));
  endtask

  logic [15:0] ra, rb;
  logic [16:0] prev, ex;

  initial begin
    // reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_res", 32'(res(8)), 32'd0);
      chk("rst_res16", 32'(res(16)), 32'd0);
    end

    // basic add
    op(8, 16'h3C, 16'h05, 17'h000, 17'h041, -1);
    fin(8, 17'h041);
    tick();
    chk("hold_idle", 32'(res(8)), 32'h041);

    // carry chain and overflow
    op(8, 16'hFF, 16'h01, 17'h041, 17'h100, -1);
    fin(8, 17'h100);
    op(8, 16'hFF, 16'hFF, 17'h100, 17'h1FE, -1);
    fin(8, 17'h1FE);

    // start ignored while busy, then back-to-back
    op(8, 16'h10, 16'h20, 17'h1FE, 17'h030, 3);
    op(8, 16'h80, 16'h80, 17'h030, 17'h100, -1);
    fin(8, 17'h100);

    // reset mid-operation
    drive(8, 1'b1, 16'hAA, 16'h55);
    tick();
    drive(8, 1'b0, 16'h00, 16'h00);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_res", 32'(res(8)), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("arst_nodone", 32'(done8), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_nodone", 32'(done8), 32'd0);
      chk("post_res", 32'(res(8)), 32'd0);
    end
    op(8, 16'h01, 16'h02, 17'h000, 17'h003, -1);
    fin(8, 17'h003);

    // 16-bit directed corners
    op(16, 16'hFFFF, 16'h0001, 17'h0, 17'h10000, -1);
    fin(16, 17'h10000);
    op(16, 16'h1234, 16'h4321, 17'h10000, 17'h05555, -1);
    fin(16, 17'h05555);

    // random operands against a+b
    prev = 17'h003;
    for (int k = 0; k < 500; k++) begin
      ra = 16'($urandom_range(255));
      rb = 16'($urandom_range(255));
      ex = {1'b0, ra} + {1'b0, rb};
      op(8, ra, rb, prev, ex, -1);
      fin(8, ex);
      prev = ex;
    end
    prev = 17'h05555;
    for (int k = 0; k < 500; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ex = {1'b0, ra} + {1'b0, rb};
      op(16, ra, rb, prev, ex, -1);
      fin(16, ex);
      prev = ex;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
